// File: rtl/vram_write_port.sv
// rtl/vram_write_port.sv - snoops CPU stores into the display file and drains them to video RAM.
// Optional BORDER_REG_EN adds a 3-bit border register loaded by IO writes to even ports.
module vram_write_port #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int          WIN_SIZE  = 6912,
  parameter int          FIFO_AW   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_dout,
  input  logic               cpu_mreq_n,
  input  logic               cpu_iorq_n,
  input  logic               cpu_wr_n,
  input  logic               vram_ready,
  output logic               vram_we,
  output logic [12:0]        vram_addr,
  output logic [7:0]         vram_din,
  output logic [FIFO_AW:0]   fifo_level,
`ifdef BORDER_REG_EN
  output logic [2:0]         border,
`endif
  output logic               overflow
);

  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0] WIN_LIMIT = 16'(WIN_SIZE);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic              mw, mw_n_q, mw_event;
  logic [15:0]       off;
  logic              in_win, push_req, push, pop, empty, full;
  logic [FIFO_AW:0]  wr_ptr, rd_ptr;
  logic [20:0]       mem [DEPTH];
  logic [20:0]       head;

  assign mw       = !cpu_mreq_n && !cpu_wr_n && cpu_iorq_n;
  assign mw_event = mw && mw_n_q;
  assign off      = cpu_addr - BASE_ADDR;
  assign in_win   = (cpu_addr >= BASE_ADDR) && (off < WIN_LIMIT);
  assign push_req = mw_event && in_win;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop   = !empty && vram_ready;
  assign push  = push_req && (!full || pop);
  assign head  = mem[rd_ptr[FIFO_AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {off[12:0], cpu_dout};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mw_n_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      mw_n_q <= !mw;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            vram_we   <= 1'b1;
            vram_addr <= head[20:8];
            vram_din  <= head[7:0];
            state     <= WRITE;
          end else begin
            vram_we <= 1'b0;
          end
        end
        WRITE: begin
          if (pop) begin
            vram_we   <= 1'b1;
            vram_addr <= head[20:8];
            vram_din  <= head[7:0];
          end else begin
            vram_we <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          vram_we <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef BORDER_REG_EN
  logic io_wr, io_n_q;
  assign io_wr = !cpu_iorq_n && !cpu_wr_n && cpu_mreq_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_n_q <= 1'b1;
      border <= 3'b000;
    end else begin
      io_n_q <= !io_wr;
      if (io_wr && io_n_q && !cpu_addr[0]) border <= cpu_dout[2:0];
    end
  end
`endif

endmodule

// File: tb/tb_vram_write_port.sv
// tb/tb_vram_write_port.sv - scoreboard bench for vram_write_port.
// Covers BORDER_REG_EN when the macro is defined.
module tb_vram_write_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_wr_n;
  logic        vram_ready;
  logic        vram_we;
  logic [12:0] vram_addr;
  logic [7:0]  vram_din;
  logic [3:0]  fifo_level;
  logic        overflow;
`ifdef BORDER_REG_EN
  logic [2:0]  border;
`endif

  vram_write_port dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_wr_n   (cpu_wr_n),
    .vram_ready (vram_ready),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_din   (vram_din),
    .fifo_level (fifo_level),
`ifdef BORDER_REG_EN
    .border     (border),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          last_we_cyc = -1;
  int          ev_cyc;
  int          base_cnt;
  logic [20:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference window model: offset into the 6912-byte display file at 0x4000.
  task automatic sb_push(input logic [15:0] a, input logic [7:0] d, input bit io, input bit drop);
    logic [15:0] o;
    o = a - 16'h4000;
    if (!io && !drop && a >= 16'h4000 && o < 16'd6912)
      exp_q.push_back({o[12:0], d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input int hold,
                        input bit io, input bit drop);
    cpu_addr = a;
    cpu_dout = d;
    cpu_wr_n = 1'b0;
    if (io) cpu_iorq_n = 1'b0;
    else    cpu_mreq_n = 1'b0;
    ev_cyc = cyc;
    sb_push(a, d, io, drop);
    repeat (hold) tick();
    cpu_mreq_n = 1'b1;
    cpu_iorq_n = 1'b1;
    cpu_wr_n   = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (reset_n && vram_we) begin
      logic [20:0] e;
      we_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", vram_addr, e[20:8]);
        check("sb_data", vram_din, e[7:0]);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    cpu_addr   = '0;
    cpu_dout   = '0;
    cpu_mreq_n = 1'b1;
    cpu_iorq_n = 1'b1;
    cpu_wr_n   = 1'b1;
    vram_ready = 1'b1;
    repeat (2) tick();
    check("rst_we", vram_we, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_din", vram_din, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
`ifdef BORDER_REG_EN
    check("rst_border", border, 0);
`endif
    reset_n = 1'b1;
    tick();

    // Single store, minimum latency
    cpu_wr(16'h4000, 8'hA5, 1, 0, 0);
    repeat (4) tick();
    check("lat_cycles", last_we_cyc - ev_cyc, 2);
    check("lat_count", we_cnt, 1);
    check("lat_level", fifo_level, 0);

    // Window boundaries
    base_cnt = we_cnt;
    cpu_wr(16'h3FFF, 8'h11, 1, 0, 0);
    cpu_wr(16'h5B00, 8'h22, 1, 0, 0);
    cpu_wr(16'h5AFF, 8'h47, 1, 0, 0);
    cpu_wr(16'h4010, 8'h33, 1, 1, 0);
    repeat (4) tick();
    check("win_count", we_cnt - base_cnt, 1);

    // Fill while stalled, overflow, then burst drain
    vram_ready = 1'b0;
    for (int i = 0; i < 8; i++) cpu_wr(16'h4000 + 16'(i), 8'h10 + 8'(i), 1, 0, 0);
    check("fill_level", fifo_level, 8);
    check("fill_ovf", overflow, 0);
    cpu_wr(16'h4008, 8'hEE, 1, 0, 1);
    check("ovf_set", overflow, 1);
    check("ovf_level", fifo_level, 8);
    check("ovf_no_we", vram_we, 0);
    vram_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("burst_we", vram_we, 1);
    end
    tick();
    check("burst_end_we", vram_we, 0);
    check("burst_end_level", fifo_level, 0);
    check("ovf_sticky", overflow, 1);

    // Long strobe yields one event
    base_cnt = we_cnt;
    cpu_wr(16'h4100, 8'h3C, 5, 0, 0);
    repeat (4) tick();
    check("hold_count", we_cnt - base_cnt, 1);

    // Simultaneous push and pop at level 3
    vram_ready = 1'b0;
    for (int i = 0; i < 3; i++) cpu_wr(16'h4200 + 16'(i), 8'h50 + 8'(i), 1, 0, 0);
    check("pp_pre_level", fifo_level, 3);
    vram_ready = 1'b1;
    cpu_addr   = 16'h4203;
    cpu_dout   = 8'h53;
    cpu_mreq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    sb_push(16'h4203, 8'h53, 0, 0);
    tick();
    check("pp_level", fifo_level, 3);
    cpu_mreq_n = 1'b1;
    cpu_wr_n   = 1'b1;
    repeat (8) tick();
    check("pp_drained", fifo_level, 0);
    check("pp_sb_empty", exp_q.size(), 0);

`ifdef BORDER_REG_EN
    base_cnt = we_cnt;
    cpu_wr(16'h00FE, 8'h05, 1, 1, 0);
    check("border_set", border, 3'b101);
    cpu_wr(16'h00FF, 8'h02, 1, 1, 0);
    repeat (3) tick();
    check("border_odd", border, 3'b101);
    check("border_no_we", we_cnt - base_cnt, 0);
`endif

    // Reset while a write is in flight
    vram_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_wr(16'h4300 + 16'(i), 8'h70 + 8'(i), 1, 0, 0);
    vram_ready = 1'b1;
    tick();
    check("mid_we", vram_we, 1);
    check("mid_level", fifo_level, 4);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_we", vram_we, 0);
    check("arst_level", fifo_level, 0);
    check("arst_ovf", overflow, 0);
    base_cnt = we_cnt;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("post_rst_writes", we_cnt - base_cnt, 0);
    check("post_rst_level", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
